// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the single-port memory arbiter
package mem_arb_pkg;

  localparam int ARB_ADDR_WIDTH = 11;
  localparam int ARB_DATA_WIDTH = 64;
  localparam int ARB_DATA_BYTES = ARB_DATA_WIDTH / 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [ARB_DATA_WIDTH-1:0] wdata;
    logic [ARB_DATA_BYTES-1:0] wen;
  } mem_req_t;

endpackage

// File: rtl/mem_sp_arbiter.sv
// rtl/mem_sp_arbiter.sv - fixed-priority arbiter sharing a write-first single-port memory
// Port 0 wins by default; port 1 is forced after MAX_WAIT denials; port 0 may lock for RMW.
module mem_sp_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int MAX_WAIT   = 4,
  parameter int WAIT_WIDTH = $clog2(MAX_WAIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  input  logic [DATA_BYTES-1:0] i_req0_wen,
  input  logic                  i_req0_lock,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_rdata,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  input  logic [DATA_BYTES-1:0] i_req1_wen,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [DATA_BYTES-1:0] o_mem_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [WAIT_WIDTH-1:0] L_MAX_WAIT = WAIT_WIDTH'(MAX_WAIT);

  lock_state_e           r_state;
  lock_state_e           w_next_state;
  logic [WAIT_WIDTH-1:0] r_wait_cnt;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [ADDR_WIDTH-1:0] r_held_addr;
  logic [DATA_WIDTH-1:0] r_held_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= UNLOCKED;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Only a port-0 transfer can move the lock; its lock bit decides the new state.
  always_comb begin
    w_next_state = r_state;
    if (w_grant0) begin
      w_next_state = i_req0_lock ? LOCKED : UNLOCKED;
    end
  end

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst_n) begin
      w_grant0 = 1'b0;
    end else if (r_state == LOCKED) begin
      w_grant0 = i_req0_valid;
    end else if ((r_wait_cnt == L_MAX_WAIT) && i_req1_valid) begin
      w_grant1 = 1'b1;
    end else if (i_req0_valid) begin
      w_grant0 = 1'b1;
    end else begin
      w_grant1 = i_req1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!i_req1_valid || w_grant1) begin
      r_wait_cnt <= '0;
    end else if ((r_state == UNLOCKED) && (r_wait_cnt != L_MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_comb begin
    o_mem_addr  = r_held_addr;
    o_mem_wdata = r_held_wdata;
    o_mem_wen   = '0;
    if (w_grant0) begin
      o_mem_addr  = i_req0_addr;
      o_mem_wdata = i_req0_wdata;
      o_mem_wen   = i_req0_wen;
    end else if (w_grant1) begin
      o_mem_addr  = i_req1_addr;
      o_mem_wdata = i_req1_wdata;
      o_mem_wen   = i_req1_wen;
    end
  end

  // Keep the bus stable while idle so the memory does not see address toggles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_held_addr  <= '0;
      r_held_wdata <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_held_addr  <= o_mem_addr;
        r_held_wdata <= o_mem_wdata;
      end
      r_rsp0_valid <= w_grant0;
      r_rsp1_valid <= w_grant1;
    end
  end

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp0_rdata = i_mem_rdata;
  assign o_rsp1_rdata = i_mem_rdata;

endmodule

// File: tb/tb_mem_sp_arbiter.sv
// tb/tb_mem_sp_arbiter.sv - directed table-driven bench for mem_sp_arbiter
module tb_mem_sp_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = ARB_ADDR_WIDTH;
  localparam int DW = ARB_DATA_WIDTH;
  localparam int BW = ARB_DATA_BYTES;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_lock, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic [BW-1:0] req0_wen;
  logic          req1_valid, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic [BW-1:0] req1_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_wen;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_sp_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_addr(req0_addr),
    .i_req0_wdata(req0_wdata), .i_req0_wen(req0_wen), .i_req0_lock(req0_lock),
    .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_addr(req1_addr),
    .i_req1_wdata(req1_wdata), .i_req1_wen(req1_wen),
    .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen),
    .i_mem_rdata(mem_rdata)
  );

  // Write-first byte-enabled single-port memory model.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    logic [DW-1:0] w;
    w = mem[mem_addr];
    for (int b = 0; b < BW; b++)
      if (mem_wen[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
    mem[mem_addr] <= w;
    mem_rdata <= w;
  end

  typedef struct {
    logic          rst;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [BW-1:0] w0;
    logic          l0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [BW-1:0] w1;
    logic          er0, er1, erv0, erv1;
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    logic [BW-1:0] ew;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DW-1:0] m(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic row(input logic rst, input logic v0, input logic [AW-1:0] a0,
                     input logic [DW-1:0] d0, input logic [BW-1:0] w0, input logic l0,
                     input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic [BW-1:0] w1, input logic er0, input logic er1,
                     input logic erv0, input logic erv1, input logic [DW-1:0] ed,
                     input logic [AW-1:0] ea, input logic [BW-1:0] ew);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.w0 = w0; v.l0 = l0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1; v.w1 = w1;
    v.er0 = er0; v.er1 = er1; v.erv0 = erv0; v.erv1 = erv1;
    v.ed = ed; v.ea = ea; v.ew = ew;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  localparam logic [DW-1:0] D = 64'hDEADBEEF_CAFEF00D;
  localparam logic [DW-1:0] X = 64'h01234567_89ABCDEF;
  localparam logic [DW-1:0] A = 64'hAAAAAAAA_AAAAAAAA;
  localparam logic [DW-1:0] B = 64'h11111111_AAAAAAAA;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = m(i);
    mem[0] = 64'h11111111_11111111;

    // Reset hold with both ports requesting, port 0 attempting a write.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 'h30; req0_wdata = A; req0_wen = '1; req0_lock = 1'b0;
    req1_valid = 1'b1; req1_addr = 'h20; req1_wdata = '0; req1_wen = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", i, 64'(req0_ready), 0);
      chk("rst_ready1", i, 64'(req1_ready), 0);
      chk("rst_mem_wen", i, 64'(mem_wen), 0);
      chk("rst_rsp0_valid", i, 64'(rsp0_valid), 0);
      chk("rst_rsp1_valid", i, 64'(rsp1_valid), 0);
      chk("rst_held_addr", i, 64'(mem_addr), 0);
      chk("rst_held_wdata", i, mem_wdata, 0);
    end
    chk("rst_no_write", 0, mem['h30], m('h30));

    // rst v0 a0 d0 w0 l0 | v1 a1 d1 w1 | rdy0 rdy1 rv0 rv1 data addr wen
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 1,0,0,0, 0,      'h10,0);
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 0,1,1,0, m('h10),'h20,0);
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 1,0,0,1, m('h20),'h10,0);
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0, 1,'h20,0,0, 0,1,1,0, m('h10),'h20,0);
    // write-first routing and byte enables
    row(1, 1,'h05,D,'1,0, 0,0,0,0,      1,0,0,1, m('h20),'h05,8'hFF);
    row(1, 0,0,0,0,0,     1,'h05,0,0,   0,1,1,0, D,      'h05,0);
    row(1, 0,0,0,0,0,     0,0,0,0,      0,0,0,1, D,      'h05,0);
    row(1, 0,0,0,0,0,     1,'h00,A,8'h0F, 0,1,0,0, 0,    'h00,8'h0F);
    row(1, 0,0,0,0,0,     0,0,0,0,      0,0,0,1, B,      'h00,0);
    // lock: port 1 stalled until after the unlocking write, counter frozen at 1
    row(1, 1,'h07,0,0,1,  1,'h20,0,0,   1,0,0,0, 0,      'h07,0);
    row(1, 0,0,0,0,0,     1,'h20,0,0,   0,0,1,0, m('h07),'h07,0);
    row(1, 0,0,0,0,0,     1,'h20,0,0,   0,0,0,0, 0,      'h07,0);
    row(1, 1,'h07,X,'1,0, 1,'h20,0,0,   1,0,0,0, 0,      'h07,8'hFF);
    row(1, 1,'h10,0,0,0,  1,'h20,0,0,   1,0,1,0, X,      'h10,0);
    row(1, 1,'h10,0,0,0,  1,'h20,0,0,   1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0,  1,'h20,0,0,   1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0,  1,'h20,0,0,   0,1,1,0, m('h10),'h20,0);
    row(1, 0,0,0,0,0,     0,0,0,0,      0,0,0,1, m('h20),'h20,0);
    // forced port 1 while port 0 asks for lock: no lock taken
    row(1, 1,'h10,0,0,0,  1,'h20,0,0,   1,0,0,0, 0,      'h10,0);
    row(1, 1,'h10,0,0,0,  1,'h20,0,0,   1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0,  1,'h20,0,0,   1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,0,  1,'h20,0,0,   1,0,1,0, m('h10),'h10,0);
    row(1, 1,'h10,0,0,1,  1,'h20,0,0,   0,1,1,0, m('h10),'h20,0);
    row(1, 0,0,0,0,0,     1,'h20,0,0,   0,1,0,1, m('h20),'h20,0);
    row(1, 0,0,0,0,0,     0,0,0,0,      0,0,0,1, m('h20),'h20,0);
    // reset right after a port 1 grant, then reset while locked
    row(1, 0,0,0,0,0,     1,'h20,0,0,   0,1,0,0, 0,      'h20,0);
    row(0, 0,0,0,0,0,     1,'h20,0,0,   0,0,0,1, m('h20),'h20,0);
    row(1, 0,0,0,0,0,     0,0,0,0,      0,0,0,0, 0,      'h00,0);
    row(1, 1,'h07,0,0,1,  0,0,0,0,      1,0,0,0, 0,      'h07,0);
    row(0, 0,0,0,0,0,     1,'h20,0,0,   0,0,1,0, X,      'h07,0);
    row(1, 0,0,0,0,0,     1,'h20,0,0,   0,1,0,0, 0,      'h20,0);
    row(1, 0,0,0,0,0,     0,0,0,0,      0,0,0,1, m('h20),'h20,0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst;
      req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_wdata = vecs[i].d0;
      req0_wen = vecs[i].w0; req0_lock = vecs[i].l0;
      req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_wdata = vecs[i].d1;
      req1_wen = vecs[i].w1;
      #1;
      chk("ready0", i, 64'(req0_ready), 64'(vecs[i].er0));
      chk("ready1", i, 64'(req1_ready), 64'(vecs[i].er1));
      chk("rsp0_valid", i, 64'(rsp0_valid), 64'(vecs[i].erv0));
      chk("rsp1_valid", i, 64'(rsp1_valid), 64'(vecs[i].erv1));
      chk("mem_addr", i, 64'(mem_addr), 64'(vecs[i].ea));
      chk("mem_wen", i, 64'(mem_wen), 64'(vecs[i].ew));
      if (vecs[i].erv0) chk("rsp0_rdata", i, rsp0_rdata, vecs[i].ed);
      if (vecs[i].erv1) chk("rsp1_rdata", i, rsp1_rdata, vecs[i].ed);
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sp_arbiter.md
Name: mem_sp_arbiter

Overview:
- Shares one synchronous single-port, write-first, byte-enabled memory between two requesters.
  - Port 0: load/store unit.
  - Port 1: instruction fetch.
- Fixed priority to port 0, with a starvation guard for port 1 and a lock for port-0 read-modify-write sequences.
- Tracks the one-cycle read latency and routes each read-data beat to the requester that issued it.
- Sits between the core's memory-facing ports and the memory instance.

Parameters:
- ADDR_WIDTH, 11, word address width.
- DATA_WIDTH, 64, data width in bits.
- DATA_BYTES, DATA_WIDTH/8, byte-enable width.
- MAX_WAIT, 4, number of consecutive cycles port 1 may be denied before it is forced; legal range 1..15.
- WAIT_WIDTH, $clog2(MAX_WAIT+1), width of the starvation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_req0_valid  in  1  port 0 request.
- o_req0_ready  out  1  port 0 granted this cycle (combinational).
- i_req0_addr  in  ADDR_WIDTH  port 0 word address.
- i_req0_wdata  in  DATA_WIDTH  port 0 write data.
- i_req0_wen  in  DATA_BYTES  port 0 byte write enables; 0 means read.
- i_req0_lock  in  1  hold the memory for port 0 after this access.
- o_rsp0_valid  out  1  port 0 response (registered).
- o_rsp0_rdata  out  DATA_WIDTH  port 0 read data.
- i_req1_valid, o_req1_ready, i_req1_addr, i_req1_wdata, i_req1_wen  as for port 0, for port 1 (no lock input).
- o_rsp1_valid  out  1  port 1 response.
- o_rsp1_rdata  out  DATA_WIDTH  port 1 read data.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_wdata  out  DATA_WIDTH  memory write data.
- o_mem_wen  out  DATA_BYTES  memory byte write enables.
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after the address.

Behaviour:
- Handshake
  - A transfer occurs when valid && ready.
  - Valid must not depend on ready.
  - At most one grant per cycle; throughput is one access per cycle.
- Grant function (combinational), based on state:
  - LOCKED: grant port 0 only.
  - UNLOCKED and wait_cnt == MAX_WAIT and req1_valid: grant port 1.
  - Otherwise grant port 0 if req0_valid, else port 1 if req1_valid.
- Memory drive
  - The granted port's addr/wdata/wen pass straight to the memory, combinationally.
  - With no grant: o_mem_wen = 0; o_mem_addr and o_mem_wdata hold the last granted values (registered copy, reset 0).
- Response
  - Every granted access, read or write, produces rsp_valid on the owning port exactly one cycle later.
  - rdata = i_mem_rdata passed through; this is the post-write word for writes.
  - rsp_valid is registered: owner flags are set on grant and cleared otherwise.
  - Both rsp_valid outputs are never high together.
  - There is no response backpressure; requesters must accept.
  - rsp*_rdata is don't-care when rsp*_valid = 0.
- Starvation counter wait_cnt (WAIT_WIDTH bits)
  - Increments, saturating at MAX_WAIT, when req1_valid && !grant1.
  - Clears when grant1, or when !req1_valid.
  - Does not increment while LOCKED.
- Lock FSM, states UNLOCKED and LOCKED
  - UNLOCKED -> LOCKED on a port 0 transfer with i_req0_lock = 1.
  - LOCKED -> UNLOCKED on a port 0 transfer with i_req0_lock = 0.
  - LOCKED with no port 0 request: the memory stays idle and port 1 stays stalled.
- Reset (rst_n = 0 at an edge)
  - State becomes UNLOCKED; wait_cnt = 0.
  - Both rsp_valid = 0; any in-flight response is dropped.
  - Held addr/wdata = 0.
  - While rst_n = 0, both readies are forced to 0 and o_mem_wen = 0.
- Simultaneous events
  - Port 1 forced by the starvation guard while port 0 also requests with lock: port 0 waits; no lock is taken that cycle.
  - Same-address write followed by read on the other port in the next cycle: the read returns the new data, by the memory's write-first semantics.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef lock_state_e {UNLOCKED, LOCKED};
  - typedef mem_req_t struct {addr, wdata, wen} built from the package constants;
  - localparam defaults ARB_ADDR_WIDTH = 11, ARB_DATA_WIDTH = 64.
- A single module is sufficient. The grant function is small enough to stay inline; no sub-module.

Test Plan:
- Reset then idle:
  - Hold rst_n = 0 for 3 cycles with both valids = 1 -> both readies = 0, o_mem_wen = 0, both rsp_valid = 0.
  - Release -> port 0 granted in the first cycle.
- Contention:
  - Both ports request continuously; port 0 reads addr 0x10, port 1 reads addr 0x20; MAX_WAIT = 4.
  - Required: port 0 granted for 4 cycles, then port 1 once, then repeat.
  - rsp1_valid one cycle after each port 1 grant, carrying mem[0x20].
- Write-first routing:
  - Port 0 writes 0xDEADBEEF_CAFEF00D to addr 5 with wen = 0xFF, then port 1 reads addr 5 the next cycle.
  - Required: rsp0_valid carries the written word; rsp1_valid the cycle after carries the same word.
- Byte enables:
  - Memory word 0 = 0x1111111111111111; port 1 writes 0xAAAAAAAAAAAAAAAA to addr 0 with wen = 0x0F.
  - Required: rsp1_rdata = 0x11111111AAAAAAAA.
- Lock:
  - Port 0 reads addr 7 with lock = 1, idles 2 cycles, then writes addr 7 with lock = 0, while port 1 requests throughout.
  - Required: port 1 receives no grant until the cycle after the unlocking write; wait_cnt frozen during LOCKED.
- Reset mid-operation:
  - Assert rst_n = 0 in the cycle after a port 1 grant -> rsp1_valid = 0 in the following cycle; FSM = UNLOCKED.
